// File: rtl/avst_sc_fifo_pkt.sv
// Single-clock Avalon-ST packet FIFO: inferred RAM plus a 2-entry show-ahead stage.
// Define AVST_FIFO_STORE_FWD_EN to hold output until a complete packet is stored.
module avst_sc_fifo_pkt #(
    parameter int DATA_W    = 24,
    parameter int EMPTY_W   = 2,
    parameter int DEPTH     = 2048,
    parameter int AFULL_TH  = DEPTH - 128,
    parameter int AEMPTY_TH = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic [DATA_W-1:0]         sink_data,
    input  logic [EMPTY_W-1:0]        sink_empty,
    input  logic                      sink_sop,
    input  logic                      sink_eop,
    input  logic                      sink_valid,
    output logic                      sink_ready,
    output logic [DATA_W-1:0]         source_data,
    output logic [EMPTY_W-1:0]        source_empty,
    output logic                      source_sop,
    output logic                      source_eop,
    output logic                      source_valid,
    input  logic                      source_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [1:0]                err_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = DATA_W + EMPTY_W + 2;
    localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_L   = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE_L   = (AW+1)'(AEMPTY_TH);

    logic [BW-1:0] mem [DEPTH];
    logic [BW-1:0] ram_q, ent0, ent1, ent0_n, ent1_n, sink_beat;
    logic [AW:0]   wr_ptr, rd_ptr, ram_cnt, lvl, lvl_n;
    logic [1:0]    out_cnt, out_cnt_n, occ, err_n;
    logic          rd_vld, rd_en, push, pop, head_ok, in_pkt, rdy;

    assign sink_beat = {sink_data, sink_empty, sink_sop, sink_eop};
    assign {source_data, source_empty, source_sop, source_eop} = ent0;
    assign sink_ready   = rdy;
    assign level        = lvl;
    assign source_valid = (out_cnt != 2'd0) & head_ok;

    assign push    = sink_valid & rdy & ~clear;
    assign pop     = source_valid & source_ready & ~clear;
    assign ram_cnt = wr_ptr - rd_ptr;
    assign occ     = out_cnt + {1'b0, rd_vld};
    // Issue a RAM read only if the show-ahead stage can absorb it next cycle.
    assign rd_en   = (ram_cnt != '0) & ~clear & ((occ != 2'd2) | pop);
    assign lvl_n   = clear ? '0 :
                     lvl + (AW+1)'(push) - (AW+1)'(pop);
    assign err_n   = clear ? 2'b00 :
                     err_sticky | {push & sink_sop & in_pkt, sink_valid & ~rdy};

    always_comb begin
        ent0_n    = ent0;
        ent1_n    = ent1;
        out_cnt_n = out_cnt - {1'b0, pop} + {1'b0, rd_vld};
        if (pop)
            ent0_n = ent1;
        if (rd_vld) begin
            if (out_cnt == 2'd0 || (out_cnt == 2'd1 && pop))
                ent0_n = ram_q;
            else
                ent1_n = ram_q;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= sink_beat;
        if (rd_en)
            ram_q <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_vld       <= 1'b0;
            out_cnt      <= 2'd0;
            ent0         <= '0;
            ent1         <= '0;
            lvl          <= '0;
            rdy          <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            err_sticky   <= 2'b00;
            in_pkt       <= 1'b0;
        end else begin
            lvl          <= lvl_n;
            rdy          <= lvl_n < FULL_L;
            almost_full  <= lvl_n >= AF_L;
            almost_empty <= lvl_n <= AE_L;
            err_sticky   <= err_n;
            if (clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                rd_vld  <= 1'b0;
                out_cnt <= 2'd0;
                in_pkt  <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr + (AW+1)'(push);
                rd_ptr  <= rd_ptr + (AW+1)'(rd_en);
                rd_vld  <= rd_en;
                out_cnt <= out_cnt_n;
                ent0    <= ent0_n;
                ent1    <= ent1_n;
                if (push & sink_eop)
                    in_pkt <= 1'b0;
                else if (push & sink_sop)
                    in_pkt <= 1'b1;
            end
        end
    end

`ifdef AVST_FIFO_STORE_FWD_EN
    logic [AW:0] pkt_cnt;
    logic        out_mid, rel, pk_in, pk_out;

    assign pk_in   = push & sink_eop;
    assign pk_out  = pop & ent0[0];
    assign head_ok = (pkt_cnt != '0) | out_mid | rel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt <= '0;
            out_mid <= 1'b0;
            rel     <= 1'b0;
        end else if (clear) begin
            pkt_cnt <= '0;
            out_mid <= 1'b0;
            rel     <= 1'b0;
        end else begin
            pkt_cnt <= pkt_cnt + (AW+1)'(pk_in) - (AW+1)'(pk_out);
            if (pop)
                out_mid <= ~ent0[0];
            // Full with no stored eop would never drain: cut through.
            if (pk_out)
                rel <= 1'b0;
            else if (lvl == FULL_L && pkt_cnt == '0)
                rel <= 1'b1;
        end
    end
`else
    assign head_ok = 1'b1;
`endif

endmodule

// File: tb/tb_avst_sc_fifo_pkt.sv
// Directed bench for avst_sc_fifo_pkt with a beat scoreboard on the source side.
module tb_avst_sc_fifo_pkt;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] sink_data = '0;
    logic [1:0]  sink_empty = '0;
    logic        sink_sop = 1'b0, sink_eop = 1'b0, sink_valid = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic [1:0]  source_empty;
    logic        source_sop, source_eop, source_valid;
    logic        source_ready = 1'b0;
    logic [11:0] level;
    logic        almost_full, almost_empty;
    logic [1:0]  err_sticky;

    int total = 0;
    int bad = 0;
    int n_pop = 0;
    int n0;
    int max_lvl = 0;
    bit in_stream = 1'b0;
    bit seen_valid = 1'b0;
    logic [27:0] sb[$];
    logic [27:0] exp_beat;

    avst_sc_fifo_pkt dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .sink_data(sink_data), .sink_empty(sink_empty),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_valid(sink_valid), .sink_ready(sink_ready),
        .source_data(source_data), .source_empty(source_empty),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_valid(source_valid), .source_ready(source_ready),
        .level(level), .almost_full(almost_full),
        .almost_empty(almost_empty), .err_sticky(err_sticky)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [23:0] d,
                         input logic [1:0] e, input logic s, input logic p);
        sink_valid = v;
        sink_data  = d;
        sink_empty = e;
        sink_sop   = s;
        sink_eop   = p;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && level != 0; i++)
            step();
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (clear) begin
                sb.delete();
            end else begin
                if (source_valid && source_ready) begin
                    n_pop++;
                    if (sb.size() == 0) begin
                        check("pop_on_empty_sb", 64'(sb.size()), 64'd1);
                    end else begin
                        exp_beat = sb.pop_front();
                        check("pop_beat",
                              {36'd0, source_data, source_empty,
                               source_sop, source_eop},
                              {36'd0, exp_beat});
                    end
                end
                if (sink_valid && sink_ready)
                    sb.push_back({sink_data, sink_empty, sink_sop, sink_eop});
            end
            if (source_valid)
                seen_valid = 1'b1;
            if (in_stream && int'(level) > max_lvl)
                max_lvl = int'(level);
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_sink_ready", sink_ready, 0);
        check("rst_source_valid", source_valid, 0);
        check("rst_level", level, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);
        check("rst_err", err_sticky, 0);
        check("rst_source_fields",
              {source_data, source_empty, source_sop, source_eop}, 0);
        reset_n = 1'b1;
        step();
        check("post_rst_sink_ready", sink_ready, 1);

        // single beat latency
        drive(1, 24'hABCDEF, 2'd1, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check("lat_level_k", level, 1);
        check("lat_valid_k", source_valid, 0);
        step();
        check("lat_valid_k1", source_valid, 0);
        step();
        check("lat_valid_k2", source_valid, 1);
        check("lat_fields",
              {source_data, source_empty, source_sop, source_eop},
              {24'hABCDEF, 2'd1, 1'b1, 1'b1});
        source_ready = 1'b1;
        step();
        check("lat_level_pop", level, 0);
        check("lat_valid_pop", source_valid, 0);

        // continuous stream
        n0 = n_pop;
        max_lvl = 0;
        in_stream = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            drive(1, 24'(i * 7 + 3), 2'(i), 1, 1);
            step();
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) step();
        in_stream = 1'b0;
        check("stream_pops_no_bubble", 64'(n_pop - n0), 64'd4096);
        check("stream_max_level_le3", 64'(max_lvl <= 3), 64'd1);
        check("stream_level_end", level, 0);

        // fill to full
        source_ready = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            drive(1, 24'(32'h5A0000 + i), 2'(i >> 2), 1, 1);
            step();
            if (level == 12'd1919)
                check("af_below_th", almost_full, 0);
            if (level == 12'd1920)
                check("af_at_th", almost_full, 1);
            if (!sink_ready)
                break;
        end
        check("full_level", level, 2048);
        check("full_sink_ready", sink_ready, 0);
        check("full_err0_before", err_sticky[0], 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("full_err0", err_sticky[0], 1);
        check("full_level_hold", level, 2048);
        n0 = n_pop;
        source_ready = 1'b1;
        drain(2200);
        step();
        check("drain_level", level, 0);
        check("drain_pops", 64'(n_pop - n0), 64'd2048);
        check("drain_sb_empty", 64'(sb.size()), 0);

        // clear at level 10
        source_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 24'(i + 100), 0, 1, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        check("pre_clear_level", level, 10);
        clear = 1'b1;
        source_ready = 1'b1;
        drive(1, 24'h111111, 0, 1, 1);
        step();
        clear = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("clear_level", level, 0);
        check("clear_valid", source_valid, 0);
        check("clear_almost_empty", almost_empty, 1);
        check("clear_err", err_sticky, 0);
        check("clear_sink_ready", sink_ready, 1);

        // sop, sop, eop
        n0 = n_pop;
        drive(1, 24'h000A01, 0, 1, 0);
        step();
        drive(1, 24'h000A02, 0, 1, 0);
        step();
        drive(1, 24'h000A03, 2'd3, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check("pkt_err1", err_sticky[1], 1);
        drain(20);
        step();
        check("pkt_pops", 64'(n_pop - n0), 64'd3);
        check("pkt_level", level, 0);

`ifdef AVST_FIFO_STORE_FWD_EN
        clear = 1'b1;
        step();
        clear = 1'b0;
        seen_valid = 1'b0;
        n0 = n_pop;
        for (int i = 0; i < 100; i++) begin
            drive(1, 24'(i + 24'h300000), 0, i == 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) step();
        check("sf_held_valid", seen_valid, 0);
        check("sf_held_level", level, 100);
        drive(1, 24'h3000FF, 2'd2, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 2 && !source_valid; i++)
            step();
        check("sf_eop_release", source_valid, 1);
        drain(300);
        step();
        check("sf_pkt_pops", 64'(n_pop - n0), 64'd101);

        seen_valid = 1'b0;
        n0 = n_pop;
        for (int i = 0; i < 2100; i++) begin
            drive(1, 24'(i + 24'h400000), 0, i == 0, 0);
            step();
            if (!sink_ready)
                break;
        end
        drive(0, 0, 0, 0, 0);
        check("sf_dl_level", level, 2048);
        check("sf_dl_no_valid", seen_valid, 0);
        for (int i = 0; i < 3 && !source_valid; i++)
            step();
        check("sf_dl_release", source_valid, 1);
        drain(2300);
        step();
        check("sf_dl_pops", 64'(n_pop - n0), 64'd2048);
        clear = 1'b1;
        step();
        clear = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
